// File: rtl/state_dump_unit.sv
// state_dump_unit: end-of-run readout that streams every register-file and data-memory word over valid/ready.
module state_dump_unit #(
    parameter int DATA_W      = 32,
    parameter int NREG        = 32,
    parameter int NMEM        = 32,
    parameter int TRIG_CYCLES = 1200,
    parameter int CNT_W       = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic              start_i,
    output logic [4:0]        rf_addr_o,
    input  logic [DATA_W-1:0] rf_data_i,
    output logic [4:0]        dm_addr_o,
    input  logic [DATA_W-1:0] dm_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic              out_sel_o,
    output logic [4:0]        out_idx_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic              out_last_o,
    output logic              freeze_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [CNT_W-1:0]  cycle_cnt_o
);
    localparam int TOTAL = NREG + NMEM;
    localparam int PW    = $clog2(TOTAL + 1);

    typedef enum logic [1:0] {IDLE, DUMP, DONE} state_t;

    state_t              state_q, state_d;
    logic [PW-1:0]       ptr_q, ptr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                valid_q, valid_d, sel_q, sel_d, last_q, last_d;
    logic [4:0]          idx_q, idx_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                is_reg, trig, load;

    // ptr spans registers first, then memory words; the inactive port reads address 0
    assign is_reg    = ptr_q < PW'(NREG);
    assign rf_addr_o = is_reg ? ptr_q[4:0] : '0;
    assign dm_addr_o = is_reg ? '0 : ptr_q[4:0] - 5'(NREG);
    assign trig      = start_i || (en_i && cnt_q == CNT_W'(TRIG_CYCLES - 1));
    assign load      = !valid_q || out_ready_i;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        valid_d = valid_q;
        sel_d   = sel_q;
        last_d  = last_q;
        idx_d   = idx_q;
        data_d  = data_q;
        cnt_d   = (state_q == IDLE && en_i && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;
        case (state_q)
            IDLE: if (trig) begin
                state_d = DUMP;
                ptr_d   = '0;
                valid_d = 1'b0;
            end
            DUMP: if (load) begin
                if (ptr_q < PW'(TOTAL)) begin
                    data_d  = is_reg ? rf_data_i : dm_data_i;
                    sel_d   = !is_reg;
                    idx_d   = is_reg ? rf_addr_o : dm_addr_o;
                    last_d  = ptr_q == PW'(TOTAL - 1);
                    valid_d = 1'b1;
                    ptr_d   = ptr_q + PW'(1);
                end else begin
                    valid_d = 1'b0;
                    state_d = DONE;
                end
            end
            DONE: if (start_i) begin
                state_d = DUMP;
                ptr_d   = '0;
                valid_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            sel_q   <= 1'b0;
            last_q  <= 1'b0;
            idx_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
        end
    end

    assign out_valid_o = valid_q;
    assign out_sel_o   = sel_q;
    assign out_idx_o   = idx_q;
    assign out_data_o  = data_q;
    assign out_last_o  = last_q;
    assign freeze_o    = state_q == DUMP;
    assign busy_o      = state_q == DUMP;
    assign done_o      = state_q == DONE;
    assign cycle_cnt_o = cnt_q;
endmodule

// File: tb/tb_state_dump_unit.sv
// tb_state_dump_unit: directed checks of trigger, streaming, backpressure, restart and reset of state_dump_unit.
module tb_state_dump_unit;
    logic        clk_i = 1'b0, rst_i = 1'b1, en_i = 1'b0, start_i = 1'b0, out_ready_i = 1'b1;
    logic [4:0]  rf_addr_o, dm_addr_o, out_idx_o;
    logic [31:0] rf_data_i, dm_data_i, out_data_o, cycle_cnt_o;
    logic        out_valid_o, out_sel_o, out_last_o, freeze_o, busy_o, done_o;
    int          n_cmp = 0, n_err = 0;

    state_dump_unit #(.TRIG_CYCLES(8)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .start_i(start_i),
        .rf_addr_o(rf_addr_o), .rf_data_i(rf_data_i),
        .dm_addr_o(dm_addr_o), .dm_data_i(dm_data_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_sel_o(out_sel_o), .out_idx_o(out_idx_o), .out_data_o(out_data_o),
        .out_last_o(out_last_o), .freeze_o(freeze_o), .busy_o(busy_o),
        .done_o(done_o), .cycle_cnt_o(cycle_cnt_o)
    );

    always #5 clk_i = ~clk_i;
    assign rf_data_i = 32'(rf_addr_o) * 3;
    assign dm_data_i = 32'(dm_addr_o) + 100;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        step();
        start_i = 1'b0;
    endtask

    // mode 0: ready high; 1: ready toggles 1,0,..; 2: ready high plus start pulse mid-dump
    task automatic run_dump(input int mode, input int abort_at, input int exp_cycles);
        int k = 0, cycles = 0;
        logic hold = 1'b0;
        logic [31:0] hdata = '0, hidx = '0;
        while (!done_o && cycles < 400) begin
            if (abort_at > 0 && k == abort_at) break;
            out_ready_i = (mode == 1) ? (cycles % 2 == 0) : 1'b1;
            start_i     = (mode == 2 && cycles == 10);
            chk("freeze", freeze_o, 1);
            chk("busy", busy_o, 1);
            if (cycles == 0) chk("first_valid", out_valid_o, 0);
            if (hold) begin
                chk("hold_data", out_data_o, hdata);
                chk("hold_idx", 32'(out_idx_o), hidx);
            end
            if (out_valid_o) begin
                chk("sel", out_sel_o, k >= 32);
                chk("idx", 32'(out_idx_o), k % 32);
                chk("data", out_data_o, k >= 32 ? 100 + k % 32 : 3 * k);
                chk("last", out_last_o, k == 63);
            end
            hold  = out_valid_o && !out_ready_i;
            hdata = out_data_o;
            hidx  = 32'(out_idx_o);
            if (out_valid_o && out_ready_i) k++;
            step();
            cycles++;
        end
        start_i = 1'b0;
        if (abort_at > 0) begin
            chk("abort_beats", k, abort_at);
        end else begin
            chk("beats", k, 64);
            chk("latency", cycles, exp_cycles);
            chk("done", done_o, 1);
            chk("freeze_done", freeze_o, 0);
            chk("valid_done", out_valid_o, 0);
        end
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        step();
        step();
        rst_i = 1'b0;
    endtask

    initial begin
        int exp_cnt, i;
        #1;
        do_reset();
        chk("rst_valid", out_valid_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_freeze", freeze_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_cnt", cycle_cnt_o, 0);
        chk("rst_sel", out_sel_o, 0);
        chk("rst_idx", 32'(out_idx_o), 0);
        chk("rst_data", out_data_o, 0);
        chk("rst_last", out_last_o, 0);
        // auto trigger after 8 enabled cycles
        en_i = 1'b1;
        for (int c = 0; c < 7; c++) step();
        chk("pre_trig_busy", busy_o, 0);
        chk("pre_trig_cnt", cycle_cnt_o, 7);
        step();
        chk("trig_busy", busy_o, 1);
        chk("trig_cnt", cycle_cnt_o, 8);
        run_dump(0, 0, 65);
        chk("cnt_after_auto", cycle_cnt_o, 8);
        // restart from DONE under backpressure
        pulse_start();
        chk("restart_done", done_o, 0);
        chk("restart_busy", busy_o, 1);
        run_dump(1, 0, 129);
        // start during DUMP ignored
        pulse_start();
        run_dump(2, 0, 65);
        step();
        chk("no_queued_start", done_o, 1);
        chk("cnt_frozen_done", cycle_cnt_o, 8);
        // reset mid-dump, then manual start with counter disabled
        en_i = 1'b0;
        pulse_start();
        run_dump(0, 20, 0);
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        chk("midrst_valid", out_valid_o, 0);
        chk("midrst_busy", busy_o, 0);
        chk("midrst_cnt", cycle_cnt_o, 0);
        chk("midrst_done", done_o, 0);
        step();
        pulse_start();
        chk("manual_busy", busy_o, 1);
        run_dump(0, 0, 65);
        chk("manual_cnt", cycle_cnt_o, 0);
        // counter gating with en_i pattern 1,1,0,0
        do_reset();
        exp_cnt = 0;
        i = 0;
        while (exp_cnt < 8 && i < 100) begin
            en_i = (i % 4) < 2;
            step();
            if (en_i) exp_cnt++;
            chk("gate_cnt", cycle_cnt_o, exp_cnt);
            chk("gate_busy", busy_o, exp_cnt == 8);
            i++;
        end
        chk("gate_cycles", i, 14);
        en_i = 1'b0;
        run_dump(0, 0, 65);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
